// File: rtl/seq1010_tx.sv
// rtl/seq1010_tx.sv - 1010-preamble serial frame transmitter with bit stuffing
// Emits PREAMBLE, DATA_W payload bits MSB-first, then GAP zeros; stuffs a 1 after any 101.
module seq1010_tx #(
  parameter int         DATA_W   = 8,
  parameter logic [3:0] PREAMBLE = 4'b1010,
  parameter int         GAP      = 2,
  parameter bit         STUFF_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              busy,
  output logic              x_out,
  output logic              sync,
  output logic              frame_done
);
  localparam int DCW = $clog2(DATA_W + 1);
  localparam int GCW = $clog2(GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_STUFF, S_GAP} state_t;

  // r_state names the class of the bit currently on x_out
  state_t            r_state, w_state_n;
  logic [1:0]        r_pcnt, w_pcnt_n;
  logic [DCW-1:0]    r_dcnt, w_dcnt_n;
  logic [GCW-1:0]    r_gcnt, w_gcnt_n;
  logic [DATA_W-1:0] r_shreg, w_shreg_n;
  logic              r_resume_gap, w_resume_gap_n;
  logic [2:0]        r_hist, w_hist_n;
  logic              r_busy, r_x, r_sync, r_done;
  logic              w_x_n, w_sync_n, w_done_n;
  logic              w_pend_data, w_pend_gap, w_stuff_go;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pcnt       <= '0;
      r_dcnt       <= '0;
      r_gcnt       <= '0;
      r_shreg      <= '0;
      r_resume_gap <= 1'b0;
      r_hist       <= 3'b000;
      r_busy       <= 1'b0;
      r_x          <= 1'b0;
      r_sync       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_pcnt       <= w_pcnt_n;
      r_dcnt       <= w_dcnt_n;
      r_gcnt       <= w_gcnt_n;
      r_shreg      <= w_shreg_n;
      r_resume_gap <= w_resume_gap_n;
      r_hist       <= w_hist_n;
      r_busy       <= (w_state_n != S_IDLE);
      r_x          <= w_x_n;
      r_sync       <= w_sync_n;
      r_done       <= w_done_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_pcnt_n       = r_pcnt;
    w_dcnt_n       = r_dcnt;
    w_gcnt_n       = r_gcnt;
    w_shreg_n      = r_shreg;
    w_resume_gap_n = r_resume_gap;
    w_pend_data    = 1'b0;
    w_pend_gap     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_n = S_PRE;
          w_pcnt_n  = 2'd0;
          w_dcnt_n  = '0;
          w_gcnt_n  = '0;
          w_shreg_n = din;
        end
      end
      S_PRE: begin
        if (r_pcnt != 2'd3) w_pcnt_n = r_pcnt + 2'd1;
        else                w_pend_data = 1'b1;
      end
      S_DATA: begin
        if (r_dcnt != DCW'(DATA_W)) w_pend_data = 1'b1;
        else                        w_pend_gap  = 1'b1;
      end
      S_STUFF: begin
        if (r_resume_gap) w_pend_gap  = 1'b1;
        else              w_pend_data = 1'b1;
      end
      S_GAP: begin
        if (r_gcnt != GCW'(GAP)) w_pend_gap = 1'b1;
        else                     w_state_n  = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase

    // A pending payload/gap bit is deferred by one stuffed 1 whenever the line just showed 101
    w_stuff_go = STUFF_EN && (r_hist == 3'b101) && (w_pend_data || w_pend_gap);
    if (w_stuff_go) begin
      w_state_n      = S_STUFF;
      w_resume_gap_n = w_pend_gap;
    end else if (w_pend_data) begin
      w_state_n = S_DATA;
      w_shreg_n = r_shreg << 1;
      w_dcnt_n  = r_dcnt + DCW'(1);
    end else if (w_pend_gap) begin
      w_state_n = S_GAP;
      w_gcnt_n  = r_gcnt + GCW'(1);
    end
  end

  always_comb begin
    w_x_n = 1'b0;
    case (w_state_n)
      S_PRE:   w_x_n = PREAMBLE[2'd3 - w_pcnt_n];
      S_DATA:  w_x_n = r_shreg[DATA_W-1];
      S_STUFF: w_x_n = 1'b1;
      default: w_x_n = 1'b0;
    endcase
    w_sync_n = (w_state_n == S_PRE) && (w_pcnt_n == 2'd3);
    w_done_n = (w_state_n == S_GAP) && (w_gcnt_n == GCW'(GAP));
    w_hist_n = (w_state_n == S_IDLE) ? 3'b000 : {r_hist[1:0], w_x_n};
  end

  assign ready      = (r_state == S_IDLE);
  assign busy       = r_busy;
  assign x_out      = r_x;
  assign sync       = r_sync;
  assign frame_done = r_done;
endmodule

// File: tb/tb_seq1010_tx.sv
// tb/tb_seq1010_tx.sv - directed and model-based checks of seq1010_tx with a 1010 detector
module tb_seq1010_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [7:0] din_a, din_b;
  logic       ready_a, busy_a, x_a, sync_a, done_a;
  logic       ready_b, busy_b, x_b, sync_b, done_b;

  seq1010_tx #(.DATA_W(8), .PREAMBLE(4'b1010), .GAP(2), .STUFF_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .din(din_a), .ready(ready_a), .busy(busy_a),
    .x_out(x_a), .sync(sync_a), .frame_done(done_a));

  seq1010_tx #(.DATA_W(8), .PREAMBLE(4'b1010), .GAP(2), .STUFF_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .din(din_b), .ready(ready_b), .busy(busy_b),
    .x_out(x_b), .sync(sync_b), .frame_done(done_b));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] dh_a = 3'b000, dh_b = 3'b000;
  logic y_a = 1'b0, y_b = 1'b0;
  int scnt_a = 0, dcnt_a = 0;
  logic [63:0] bits, ym, sm, dm, exp_bits;
  int len, exp_len, s0, d0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample on the falling edge and run the receiver's overlapping Mealy 1010 detector
  task automatic step();
    @(negedge clk);
    y_a  = !rst && (dh_a == 3'b101) && !x_a;
    dh_a = rst ? 3'b000 : {dh_a[1:0], x_a};
    y_b  = !rst && (dh_b == 3'b101) && !x_b;
    dh_b = rst ? 3'b000 : {dh_b[1:0], x_b};
    if (sync_a) scnt_a++;
    if (done_a) dcnt_a++;
  endtask

  task automatic capture(input bit sel, input logic [63:0] sprog, input logic [7:0] dnext,
                         output logic [63:0] b, output logic [63:0] y, output logic [63:0] s,
                         output logic [63:0] d, output int n);
    b = '0; y = '0; s = '0; d = '0; n = 0;
    while ((sel ? busy_b : busy_a) && n < 60) begin
      n++;
      b = {b[62:0], sel ? x_b : x_a};
      y = {y[62:0], sel ? y_b : y_a};
      s = {s[62:0], sel ? sync_b : sync_a};
      d = {d[62:0], sel ? done_b : done_a};
      if (sel) start_b = sprog[n]; else start_a = sprog[n];
      if (n == 3) begin
        if (sel) din_b = dnext; else din_a = dnext;
      end
      step();
    end
  endtask

  function automatic void model(input logic [7:0] d, output logic [63:0] b, output int n);
    logic [2:0]  h;
    logic [13:0] v;
    v = {4'b1010, d, 2'b00};
    b = '0; n = 0; h = 3'b000;
    for (int k = 13; k >= 0; k--) begin
      if (k < 10 && h == 3'b101) begin
        b = {b[62:0], 1'b1}; n++; h = {h[1:0], 1'b1};
      end
      b = {b[62:0], v[k]}; n++; h = {h[1:0], v[k]};
    end
  endfunction

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; din_a = 8'h00; din_b = 8'h00;
    step(); step();
    check("rst_x", x_a, 1'b0);
    check("rst_ready", ready_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_sync_done", {sync_a, done_a}, 2'b00);
    rst = 1'b0;
    step();

    // A5 with stuffing: three stuffed ones
    din_a = 8'hA5; start_a = 1'b1; step();
    capture(1'b0, 64'd0, 8'h00, bits, ym, sm, dm, len);
    check("a5_len", len, 17);
    check("a5_bits", bits, 17'b10101101100101100);
    check("a5_y", ym, 17'b00010000000000000);
    check("a5_sync", sm, 17'b00010000000000000);
    check("a5_done", dm, 17'b00000000000000001);

    // AA raw: detector fires five times
    din_b = 8'hAA; start_b = 1'b1; step();
    capture(1'b1, 64'd0, 8'h00, bits, ym, sm, dm, len);
    check("aa_raw_len", len, 14);
    check("aa_raw_bits", bits, 14'b10101010101000);
    check("aa_raw_y", ym, 14'b00010101010100);
    check("aa_raw_sync", sm, 14'b00010000000000);

    // AA stuffed: detector fires on the preamble only
    din_a = 8'hAA; start_a = 1'b1; step();
    capture(1'b0, 64'd0, 8'h00, bits, ym, sm, dm, len);
    check("aa_stf_len", len, 18);
    check("aa_stf_bits", bits, 18'b101011011011011000);
    check("aa_stf_y", ym, 18'b000100000000000000);

    // start held for three frames, din changed mid-frame
    s0 = scnt_a; d0 = dcnt_a;
    din_a = 8'h00; start_a = 1'b1; step();
    capture(1'b0, '1, 8'hFF, bits, ym, sm, dm, len);
    check("held1_len", len, 14);
    check("held1_bits", bits, 14'b10100000000000);
    check("held1_gap", {ready_a, busy_a, x_a}, 3'b100);
    step();
    capture(1'b0, '1, 8'h5A, bits, ym, sm, dm, len);
    check("held2_len", len, 15);
    check("held2_bits", bits, 15'b101011111111100);
    check("held2_gap", {ready_a, busy_a, x_a}, 3'b100);
    step();
    capture(1'b0, 64'd0, 8'h33, bits, ym, sm, dm, len);
    check("held3_len", len, 16);
    check("held3_bits", bits, 16'b1010010111011000);
    step();
    check("held_stop", busy_a, 1'b0);
    check("held_syncs", scnt_a - s0, 3);
    check("held_dones", dcnt_a - d0, 3);

    // start pulsed mid-PRE and mid-GAP is ignored
    din_a = 8'hA5; start_a = 1'b1; step();
    capture(1'b0, (64'd1 << 2) | (64'd1 << 16), 8'h00, bits, ym, sm, dm, len);
    check("busy_start_len", len, 17);
    check("busy_start_bits", bits, 17'b10101101100101100);
    check("busy_start_done", dm, 17'b00000000000000001);
    check("busy_start_ready", ready_a, 1'b1);
    step();
    check("busy_start_noqueue", busy_a, 1'b0);

    // asynchronous reset mid-DATA
    din_a = 8'hA5; start_a = 1'b1; step(); start_a = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_x", {busy_a, x_a}, 2'b11);
    rst = 1'b1;
    #1;
    check("async_rst_outs", {x_a, sync_a, done_a, busy_a}, 4'b0000);
    check("async_rst_ready", ready_a, 1'b1);
    step();
    rst = 1'b0;
    step();
    din_a = 8'hA5; start_a = 1'b1; step();
    capture(1'b0, 64'd0, 8'h00, bits, ym, sm, dm, len);
    check("post_rst_len", len, 17);
    check("post_rst_bits", bits, 17'b10101101100101100);

    // random payloads against the behavioural model
    for (int f = 0; f < 40; f++) begin
      din_a = 8'($urandom); start_a = 1'b1;
      model(din_a, exp_bits, exp_len);
      step();
      capture(1'b0, 64'd0, din_a, bits, ym, sm, dm, len);
      check("rnd_len", len, exp_len);
      check("rnd_bits", bits, exp_bits);
      check("rnd_ycount", $countones(ym), 1);
      check("rnd_y_eq_sync", ym, sm);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
